// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, one-hot port type, arbiter states.
package noc_pkg;
    localparam int NUM_PORTS  = 5;
    localparam int PORT_LOCAL = 0;
    localparam int PORT_NORTH = 1;
    localparam int PORT_EAST  = 2;
    localparam int PORT_SOUTH = 3;
    localparam int PORT_WEST  = 4;

    typedef logic [NUM_PORTS-1:0] port_oh_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;
endpackage

// File: rtl/rr_pick_5.sv
// Combinational 5-way round-robin picker (double-width mask trick).
// Returns the first set req bit at or cyclically after the one-hot pointer.
module rr_pick_5
    import noc_pkg::*;
(
    input  logic [4:0] req,
    input  logic [4:0] pointer,
    output logic [4:0] grant
);
    logic [9:0] req2;
    logic [9:0] diff;
    logic [9:0] gnt2;

    // Subtracting the pointer from the doubled request vector clears every
    // set bit below the first one at/after the pointer, wrap included.
    always_comb begin
        req2  = {req, req};
        diff  = req2 - {5'b00000, pointer};
        gnt2  = req2 & ~diff;
        grant = gnt2[9:5] | gnt2[4:0];
    end
endmodule

// File: rtl/sw_port_arbiter_5.sv
// Per-output-port wormhole switch arbiter: round-robin pick, head-to-tail
// lock, credit-gated flit transfer with sticky credit-overflow flag.
module sw_port_arbiter_5
    import noc_pkg::*;
#(
    parameter  int CREDITS = 4,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    req_i,
    input  logic [4:0]    tail_i,
    input  logic          credit_upd_i,
    output logic [4:0]    grant_o,
    output logic          fire_o,
    output logic [CW-1:0] credit_cnt_o,
    output logic          credit_err_o
);
    arb_state_e    state_q, state_d;
    port_oh_t      grant_q, grant_d;
    port_oh_t      ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    port_oh_t      pick;
    logic          fire;
    logic          tail_fire;

    rr_pick_5 u_pick (
        .req     (req_i),
        .pointer (ptr_q),
        .grant   (pick)
    );

    // Transfer gating: owner has a flit and downstream has room.
    always_comb begin
        fire      = (|(grant_q & req_i)) && (cnt_q != '0);
        tail_fire = fire && (|(grant_q & tail_i));
    end

    // Arbitration FSM: pick in IDLE, hold the grant until the tail moves.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                grant_d = '0;
                if (|req_i) begin
                    grant_d = pick;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (tail_fire) begin
                    grant_d = '0;
                    ptr_d   = {grant_q[3:0], grant_q[4]};
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Credit counter: fire consumes, upd returns, both cancel; overflow is sticky.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (fire && !credit_upd_i) begin
            cnt_d = cnt_q - CW'(1);
        end else if (credit_upd_i && !fire) begin
            if (cnt_q == CW'(CREDITS)) err_d = 1'b1;
            else                       cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= 5'b00001;
            cnt_q   <= CW'(CREDITS);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign grant_o      = grant_q;
    assign fire_o       = fire;
    assign credit_cnt_o = cnt_q;
    assign credit_err_o = err_q;
endmodule

// File: doc/sw_port_arbiter_5.md
Name: sw_port_arbiter_5

Overview:
- Per-output-port switch arbiter for a 5-port wormhole NoC router.
- Shares one output port between 5 input-port requesters using round-robin order.
- Generates the one-hot select that drives the output-port mux_5.
- Holds the grant from head flit to tail flit.
- Gates every flit transfer on downstream credit, tracked by an internal credit counter.

Parameters:
- CREDITS, 4: downstream buffer depth in flits; also the credit counter reset value (must be >= 1).
- CW, $clog2(CREDITS+1): credit counter width (derived; do not override).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_i  input  5  bit k: input port k has a flit valid for this output port.
- tail_i  input  5  bit k: input port k's current flit is a tail (single-flit packet = head+tail).
- credit_upd_i  input  1  one credit returned by downstream this cycle.
- grant_o  output  5  one-hot owner select to mux_5; 5'b00000 when idle.
- fire_o  output  1  a flit transfers this cycle; the owner pops its flit when fire_o is high.
- credit_cnt_o  output  CW  current credit count.
- credit_err_o  output  1  sticky flag: credit returned while the counter was already at CREDITS.

Behaviour:
- Reset values (async, immediate): state=IDLE, grant_o=0, pointer=5'b00001, credit_cnt_o=CREDITS, credit_err_o=0. fire_o=0 follows from grant_o=0.
- Reset mid-packet abandons the lock with no flush; the upstream port restarts its packet.
- State machine: IDLE and LOCKED.
- IDLE, any req_i bit set:
  - Pick the first set bit at or cyclically after pointer (bit order 0→4, wrap 4→0).
  - Register the pick into grant_o and go to LOCKED next cycle.
  - Arbitration does not depend on credit.
- IDLE, req_i=0: stay in IDLE, grant_o=0.
- Latency: a request in cycle N gives grant_o in cycle N+1. The earliest fire_o for the head flit is cycle N+1.
- fire_o is combinational: fire_o = |(grant_o & req_i) && credit_cnt_o != 0.
- LOCKED:
  - grant_o holds its value.
  - If the owner drops req_i mid-packet, the lock is held and fire_o=0 (wormhole bubble).
  - Requests from other ports are ignored.
- Release: fire_o && tail_i[owner] in cycle M. Then:
  - In M+1: state=IDLE, grant_o=0, pointer = owner rotated left by 1 (owner bit 4 → 5'b00001).
  - The earliest new grant is M+2. This one-cycle bubble after each packet is required.
- Credit counter:
  - fire_o only: decrement.
  - credit_upd_i only: increment.
  - Both in the same cycle: unchanged.
  - fire_o is never asserted at 0, so the counter never underflows.
  - credit_upd_i at CREDITS: count saturates at CREDITS, and credit_err_o is set and stays set until rst.
- Credit return has no latency requirement: a credit returned in cycle M allows fire_o in M+1.
- grant_o is always one-hot or zero. An assertion in the bench checks this every cycle.

Decomposition:
- noc_pkg holds:
  - port index constants PORT_LOCAL=0, PORT_NORTH=1, PORT_EAST=2, PORT_SOUTH=3, PORT_WEST=4.
  - NUM_PORTS=5.
  - typedef port_oh_t (logic [4:0]).
  - arbiter state enum {ARB_IDLE, ARB_LOCKED}.
- Sub-module rr_pick_5: combinational round-robin picker.
  - Inputs: req[4:0], one-hot pointer[4:0].
  - Output: one-hot grant[4:0]; zero when req=0.
  - Implemented with the double-width mask trick. It is reused by the VC allocator.

Test Plan:
- Single request: reset, req_i=5'b00100 with tail_i=5'b00100 in cycle 1 → grant_o=5'b00100 and fire_o=1 in cycle 2; grant_o=0 and pointer=5'b01000 in cycle 3; credit_cnt_o=3.
- Round-robin fairness: req_i=5'b11111 held, every flit a tail, credit_upd_i pulsed on each fire → grants 00001,00010,00100,01000,10000,00001 in turn, each separated by one idle cycle.
- Wormhole lock: port 1 sends a 3-flit packet (tail on the 3rd) while port 3 requests continuously, with a 2-cycle req drop by port 1 after flit 1 → grant_o stays 5'b00010 throughout with fire_o=0 during the drop; port 3 is granted 2 cycles after the tail fires.
- Credit exhaustion: CREDITS=4, port 0 sends a 6-flit packet with no credit_upd_i → 4 fires then fire_o=0 with credit_cnt_o=0. One credit_upd_i pulse → exactly one more fire. Simultaneous fire and credit_upd_i → count unchanged.
- Credit overflow: credit_upd_i at credit_cnt_o=4 → count stays 4, credit_err_o=1, and it stays 1 until rst.
- Reset mid-packet: assert rst while grant_o=5'b01000 mid-packet → grant_o=0, credit_cnt_o=4 and pointer=5'b00001 immediately. After deassert, with req_i=5'b01001 → port 0 is granted first.
